apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 8, width of req_addr and padd.
REQ-002 Parameter DATA_W, default 32, width of all data buses.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS wait cycles without pready; 0 disables the timeout.
REQ-004 pclk  in  1  sole clock; all logic on the rising edge.
REQ-005 prst  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  1  upstream request present.
REQ-007 req_ready  out  1  block accepts a request this cycle.
REQ-008 req_wr  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  transfer address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
REQ-013 rsp_err  out  1  slave error or timeout, qualified by rsp_valid.
REQ-014 psel, penable, pwr  out  1 each  APB control to the slave.
REQ-015 padd  out  ADDR_W; pwdata  out  DATA_W  APB address and write data.
REQ-016 prdata  in  DATA_W; pready  in  1; pslverr  in  1  APB slave response.

Function
REQ-017 The state machine SHALL have states IDLE, SETUP and ACCESS.
REQ-018 req_ready SHALL be 1 only in IDLE; a handshake is req_valid & req_ready.
REQ-019 On a handshake, req_wr, req_addr and req_wdata SHALL be registered, and the state SHALL move to SETUP at the next edge.
REQ-020 In SETUP: psel=1, penable=0; pwr, padd and pwdata equal the captured values; the next state SHALL be ACCESS unconditionally.
REQ-021 In ACCESS: psel=1, penable=1; pwr, padd and pwdata SHALL be held stable until the transfer completes.
REQ-022 ACCESS SHALL complete on the first edge that samples pready=1.
REQ-023 At completion: rsp_valid=1 for exactly one cycle after that edge; rsp_err=pslverr; rsp_rdata=prdata for reads, 0 for writes.
REQ-024 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with pready=0.
REQ-025 When TIMEOUT>0 and the counter reaches TIMEOUT, ACCESS SHALL terminate with rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-026 If pready=1 in the same cycle the count reaches TIMEOUT, this SHALL count as normal completion (pready wins).
REQ-027 After completion the state SHALL return to IDLE with psel=penable=0; minimum transfer period is 3 cycles (IDLE, SETUP, ACCESS).
REQ-028 pready and pslverr SHALL be ignored outside ACCESS.
REQ-029 In IDLE, padd, pwdata and pwr SHALL retain their last values.
REQ-030 The counter width SHALL be $clog2(TIMEOUT+1), with a minimum of 1, and it SHALL saturate with no wrap.

Reset
REQ-031 While prst=0: state=IDLE, all outputs 0, wait counter 0.
REQ-032 A reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid; after deassertion, req_ready=1 on the first cycle.

Structure
REQ-033 apb_package SHALL hold the state enum type, the default ADDR_W and DATA_W, and a response struct type {rdata, err}.
REQ-034 The wait counter and timeout compare SHALL be a sub-module, apb_master_timer, with inputs clear and enable and output expired.

Verification
REQ-035 Write addr 0x10, data 0xA5A5_0001, pready tied 1 -> psel at cycle +1, penable at +2, rsp_valid at +3 with err=0 and rdata=0.
REQ-036 Read addr 0x10 after that write -> rsp_rdata=0xA5A5_0001, err=0, and padd stable through SETUP/ACCESS.
REQ-037 Read with slave holding pready=0 for 5 cycles -> ACCESS lasts 6 cycles, signals stable, one rsp_valid pulse.
REQ-038 pready never asserted, TIMEOUT=16 -> rsp_valid with err=1 and rdata=0 after 16 ACCESS cycles, then IDLE.
REQ-039 Write returning pslverr=1 -> rsp_err=1; then a back-to-back read whose req_valid is held high is accepted the cycle after the IDLE return.
REQ-040 prst pulsed low during ACCESS -> psel, penable and rsp_valid are 0 immediately, and no response is issued for the abandoned transfer.

Source files
------------

// File: rtl/apb_package.sv
// Shared types and defaults for the APB master: FSM state encoding, bus widths,
// response record and the wait-counter width rule.
package apb_package;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

  // Counter must hold TIMEOUT; a disabled timeout still gets a 1-bit counter.
  function automatic int apb_cnt_w(input int timeout);
    int w;
    w = (timeout > 0) ? $clog2(timeout + 1) : 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_master_timer.sv
// ACCESS wait counter. expired flags the wait cycle whose increment would make
// the count reach TIMEOUT, so the transfer ends after exactly TIMEOUT waits.
module apb_master_timer
  import apb_package::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic prst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = apb_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst)                    cnt_q <= '0;
    else if (clear)               cnt_q <= '0;
    else if (enable && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end

  // enable is low whenever pready is high, so a ready slave always beats expiry.
  assign expired = (TIMEOUT > 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: takes one upstream request, runs SETUP/ACCESS
// on the bus, and returns a one-cycle response with read data and error.
module apb_master
  import apb_package::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwr,
  output logic [ADDR_W-1:0] padd,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e state_q, state_d;
  logic       done, tmo, expired;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (expired) begin
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Gating with prst keeps req_ready low during reset yet high on the first
  // cycle after release.
  assign req_ready = prst && (state_q == ST_IDLE);
  assign psel      = (state_q != ST_IDLE);
  assign penable   = (state_q == ST_ACCESS);

  // Bus address/data/direction hold their last values between transfers.
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      pwr    <= 1'b0;
      padd   <= '0;
      pwdata <= '0;
    end else if (state_q == ST_IDLE && req_valid) begin
      pwr    <= req_wr;
      padd   <= req_addr;
      pwdata <= req_wdata;
    end
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done | tmo;
      rsp_err   <= tmo | (done & pslverr);
      rsp_rdata <= (done && !pwr) ? prdata : '0;
    end
  end

  apb_master_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .pclk    (pclk),
    .prst    (prst),
    .clear   (state_q == ST_SETUP),
    .enable  ((state_q == ST_ACCESS) && !pready),
    .expired (expired)
  );

endmodule

// File: tb/tb_apb_master.sv
// Randomized self-checking bench for apb_master: a behavioural slave with
// programmable wait states plus a transaction-level memory/latency model.
module tb_apb_master;
  import apb_package::*;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          pclk = 1'b0;
  logic          prst;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr, padd;
  logic [DW-1:0] req_wdata, pwdata, prdata, rsp_rdata;
  logic          rsp_valid, rsp_err, psel, penable, pwr, pready, pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] smem    [256];
  int            s_waits = 0;
  logic          s_err   = 1'b0;
  int            acc_n   = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            waits;
    logic          serr;
  } xfer_t;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwr(pwr), .padd(padd), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Slave: raises pready after s_waits ACCESS cycles; junk elsewhere.
  always @(negedge pclk) begin
    if (psel && penable) begin
      if (acc_n >= s_waits) begin
        pready  = 1'b1;
        pslverr = s_err;
        prdata  = pwr ? DW'($urandom) : smem[padd];
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = DW'($urandom);
      end
      acc_n++;
    end else begin
      acc_n   = 0;
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = DW'($urandom);
    end
  end

  always @(posedge pclk)
    if (prst && psel && penable && pready && pwr && !pslverr) smem[padd] <= pwdata;

  // Runs one transfer from a negedge with req_valid asserted until the response.
  task automatic wait_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int waits, input logic serr, input bit keep,
                           input logic nwr, input logic [AW-1:0] naddr,
                           input logic [DW-1:0] nwd, input string tag);
    int cyc, acc, unstable, first_sel, first_en, exp_acc;
    bit tmo;
    apb_rsp_t exp;
    tmo       = (waits >= TMO);
    exp_acc   = tmo ? TMO : waits + 1;
    exp.err   = tmo | serr;
    exp.rdata = (wr || tmo) ? '0 : ref_mem[addr];
    if (wr && !tmo && !serr) ref_mem[addr] = wd;
    s_waits   = waits;
    s_err     = serr;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s req_ready: got %b expected 1", tag, req_ready);
    end
    cyc = 0; acc = 0; unstable = 0; first_sel = -1; first_en = -1;
    while (cyc < 60) begin
      @(negedge pclk);
      cyc++;
      if (cyc == 1) begin
        if (keep) begin
          req_wr = nwr; req_addr = naddr; req_wdata = nwd;
        end else begin
          req_valid = 1'b0;
          req_wr = 1'($urandom_range(0, 1)); req_addr = AW'($urandom); req_wdata = DW'($urandom);
        end
      end
      if (rsp_valid) break;
      if (psel && first_sel < 0) first_sel = cyc;
      if (penable && first_en < 0) first_en = cyc;
      if (psel && penable) acc++;
      if (psel && (padd !== addr || pwr !== wr || pwdata !== wd)) unstable++;
    end
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_bad++; $display("FAIL %s no_response: got none within %0d cycles", tag, cyc);
      req_valid = 1'b0;
      return;
    end
    n_cmp++;
    if (first_sel !== 1 || first_en !== 2 || cyc !== exp_acc + 2) begin
      n_bad++;
      $display("FAIL %s timing: psel@%0d penable@%0d rsp@%0d expected 1/2/%0d",
               tag, first_sel, first_en, cyc, exp_acc + 2);
    end
    n_cmp++;
    if (acc !== exp_acc) begin
      n_bad++; $display("FAIL %s access_cycles: got %0d expected %0d", tag, acc, exp_acc);
    end
    n_cmp++;
    if (unstable !== 0) begin
      n_bad++; $display("FAIL %s bus_stable: got %0d unstable cycles expected 0", tag, unstable);
    end
    n_cmp++;
    if (rsp_err !== exp.err || rsp_rdata !== exp.rdata) begin
      n_bad++;
      $display("FAIL %s response: got err=%b rdata=%h expected err=%b rdata=%h",
               tag, rsp_err, rsp_rdata, exp.err, exp.rdata);
    end
    n_cmp++;
    if (psel !== 1'b0 || penable !== 1'b0 || padd !== addr) begin
      n_bad++;
      $display("FAIL %s idle_return: got psel=%b penable=%b padd=%h expected 0/0/%h",
               tag, psel, penable, padd, addr);
    end
    if (!keep) begin
      @(negedge pclk);
      n_cmp++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL %s single_pulse: got rsp_valid=%b req_ready=%b expected 0/1",
                 tag, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_reset();
    prst = 1'b0;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h5A; req_wdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge pclk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, psel, penable, pwr} !== 6'b0 ||
        padd !== '0 || pwdata !== '0 || rsp_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b sel=%b en=%b wr=%b padd=%h pwdata=%h rdata=%h expected all 0",
               req_ready, rsp_valid, rsp_err, psel, penable, pwr, padd, pwdata, rsp_rdata);
    end
    req_valid = 1'b0;
    prst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
    @(negedge pclk);
  endtask

  task automatic test_write_basic();
    wait_xfer(1'b1, 8'h10, 32'hA5A5_0001, 0, 1'b0, 1'b0, 1'b0, '0, '0, "write_basic");
  endtask

  task automatic test_read_back();
    wait_xfer(1'b0, 8'h10, DW'($urandom), 0, 1'b0, 1'b0, 1'b0, '0, '0, "read_back");
  endtask

  task automatic test_wait_states();
    wait_xfer(1'b0, 8'h10, DW'($urandom), 5, 1'b0, 1'b0, 1'b0, '0, '0, "wait_states");
  endtask

  task automatic test_timeout();
    wait_xfer(1'b0, 8'h10, DW'($urandom), 1000, 1'b0, 1'b0, 1'b0, '0, '0, "timeout");
  endtask

  task automatic test_pready_wins();
    wait_xfer(1'b1, 8'h30, 32'h1234_5678, TMO - 1, 1'b0, 1'b0, 1'b0, '0, '0, "pready_wins_wr");
    wait_xfer(1'b0, 8'h30, DW'($urandom), 0, 1'b0, 1'b0, 1'b0, '0, '0, "pready_wins_rd");
  endtask

  task automatic test_back_to_back();
    wait_xfer(1'b1, 8'h10, 32'h0BAD_0BAD, 1, 1'b1, 1'b1, 1'b0, 8'h10, 32'h0, "slverr_wr");
    wait_xfer(1'b0, 8'h10, 32'h0, 0, 1'b0, 1'b0, 1'b0, '0, '0, "b2b_rd");
  endtask

  task automatic test_reset_in_access();
    int stray;
    s_waits = 1000; s_err = 1'b0;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h10; req_wdata = 32'hFFFF_0000;
    @(negedge pclk);
    req_valid = 1'b0;
    repeat (3) @(negedge pclk);
    prst = 1'b0;
    #1;
    n_cmp++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_abort: got psel=%b penable=%b rsp_valid=%b expected 0/0/0",
               psel, penable, rsp_valid);
    end
    repeat (2) @(negedge pclk);
    prst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_abort_ready: got %b expected 1", req_ready);
    end
    stray = 0;
    repeat (20) begin
      @(negedge pclk);
      if (rsp_valid || psel) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin
      n_bad++; $display("FAIL reset_abort_quiet: got %0d active cycles expected 0", stray);
    end
  endtask

  task automatic test_random();
    xfer_t tq[$];
    xfer_t t, nx;
    bit keep;
    for (int i = 0; i < 30; i++) begin
      t.wr    = 1'($urandom_range(0, 1));
      t.addr  = AW'(8'h10 + $urandom_range(0, 7));
      t.wd    = DW'($urandom);
      t.waits = ($urandom_range(0, 9) == 9) ? $urandom_range(TMO - 2, TMO + 1) : $urandom_range(0, 3);
      t.serr  = ($urandom_range(0, 7) == 0);
      tq.push_back(t);
    end
    for (int i = 0; i < tq.size(); i++) begin
      keep = (i + 1 < tq.size()) && ($urandom_range(0, 1) == 1);
      nx   = keep ? tq[i+1] : tq[i];
      wait_xfer(tq[i].wr, tq[i].addr, tq[i].wd, tq[i].waits, tq[i].serr,
                keep, nx.wr, nx.addr, nx.wd, $sformatf("random%0d", i));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      smem[i]    = '0;
    end
    prst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge pclk);
    test_reset();
    test_write_basic();
    test_read_back();
    test_wait_states();
    test_timeout();
    test_pready_wins();
    test_back_to_back();
    test_reset_in_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
